// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: default widths, functional-unit indices and the CDB payload.
package tomasulo_pkg;

    localparam int unsigned DEFAULT_TAG_W  = 4;
    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned NUM_UNITS      = 3;
    localparam int unsigned UNIT_W         = 2;

    localparam logic [UNIT_W-1:0] UNIT_ALU    = 2'd0;
    localparam logic [UNIT_W-1:0] UNIT_MULDIV = 2'd1;
    localparam logic [UNIT_W-1:0] UNIT_LOAD   = 2'd2;

    typedef struct packed {
        logic                      valid;
        logic [DEFAULT_TAG_W-1:0]  tag;
        logic [DEFAULT_DATA_W-1:0] value;
        logic [UNIT_W-1:0]         unit;
    } cdb_result_t;

    // Round-robin successor over the three units; index 3 is never produced.
    function automatic logic [UNIT_W-1:0] next_unit(input logic [UNIT_W-1:0] u);
        return (u == UNIT_LOAD) ? UNIT_ALU : u + 2'd1;
    endfunction

endpackage

// File: rtl/cdb_slot.sv
// Per-unit result holding buffer; single entry by default, 2-entry FIFO when
// CDB_DEEP_BUFFER_EN is defined.
module cdb_slot #(
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [DATA_W-1:0] value_i,
    input  logic              pop_i,
    output logic              ready_o,
    output logic              pending_o,
    output logic [TAG_W-1:0]  head_tag_o,
    output logic [DATA_W-1:0] head_value_o
);

    logic push;
    logic pop;

`ifdef CDB_DEEP_BUFFER_EN
    logic [TAG_W-1:0]  tag_q   [2];
    logic [DATA_W-1:0] value_q [2];
    logic [1:0]        count_q, count_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;

    assign ready_o      = (count_q != 2'd2);
    assign pending_o    = (count_q != 2'd0);
    assign push         = push_i & ready_o;
    assign pop          = pop_i & pending_o;
    assign head_tag_o   = tag_q[rd_q];
    assign head_value_o = value_q[rd_q];

    // Occupancy and pointer update; push and pop may coincide.
    always_comb begin
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (push) wr_d = ~wr_q;
        if (pop)  rd_d = ~rd_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[wr_q]   <= tag_i;
            value_q[wr_q] <= value_i;
        end
    end
`else
    logic              full_q, full_d;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] value_q;

    assign ready_o      = ~full_q;
    assign pending_o    = full_q;
    assign push         = push_i & ~full_q;
    assign pop          = pop_i & full_q;
    assign head_tag_o   = tag_q;
    assign head_value_o = value_q;

    // Accept only when empty, so push and pop are mutually exclusive.
    always_comb begin
        full_d = full_q;
        if (push)     full_d = 1'b1;
        else if (pop) full_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) full_q <= 1'b0;
        else     full_q <= full_d;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_q   <= tag_i;
            value_q <= value_i;
        end
    end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers completed results from three functional units and
// broadcasts one per cycle in round-robin order. Slot depth follows CDB_DEEP_BUFFER_EN.
module cdb_arbiter
    import tomasulo_pkg::*;
#(
    parameter int unsigned TAG_W  = DEFAULT_TAG_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_UNITS-1:0] fu_valid,
    input  logic [TAG_W-1:0]     fu_tag   [NUM_UNITS],
    input  logic [DATA_W-1:0]    fu_value [NUM_UNITS],
    output logic [NUM_UNITS-1:0] fu_ready,
    output logic                 cdb_valid,
    output logic [TAG_W-1:0]     cdb_tag,
    output logic [DATA_W-1:0]    cdb_value,
    output logic [UNIT_W-1:0]    cdb_unit
);

    logic [NUM_UNITS-1:0] pending;
    logic [NUM_UNITS-1:0] grant_oh;
    logic [TAG_W-1:0]     head_tag   [NUM_UNITS];
    logic [DATA_W-1:0]    head_value [NUM_UNITS];

    logic [UNIT_W-1:0] ptr_q, ptr_d;
    logic [UNIT_W-1:0] winner;
    logic [UNIT_W-1:0] cand;
    logic [2:0]        sum;
    logic              grant_any;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_value;

    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
    logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
    logic [UNIT_W-1:0] cdb_unit_q,  cdb_unit_d;

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_slot
        cdb_slot #(
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .push_i       (fu_valid[u]),
            .tag_i        (fu_tag[u]),
            .value_i      (fu_value[u]),
            .pop_i        (grant_oh[u]),
            .ready_o      (fu_ready[u]),
            .pending_o    (pending[u]),
            .head_tag_o   (head_tag[u]),
            .head_value_o (head_value[u])
        );
    end

    // Round-robin search starting at the pointer, then register the winner onto the bus.
    always_comb begin
        grant_any = 1'b0;
        winner    = ptr_q;
        sum       = 3'd0;
        cand      = ptr_q;
        grant_oh  = '0;
        sel_tag   = '0;
        sel_value = '0;

        for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            sum  = 3'(ptr_q) + 3'(k);
            cand = (sum >= 3'(NUM_UNITS)) ? 2'(sum - 3'(NUM_UNITS)) : 2'(sum);
            if (!grant_any && pending[cand]) begin
                grant_any = 1'b1;
                winner    = cand;
            end
        end

        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            grant_oh[u] = grant_any && (winner == UNIT_W'(u));
            if (grant_oh[u]) begin
                sel_tag   = head_tag[u];
                sel_value = head_value[u];
            end
        end

        ptr_d       = grant_any ? next_unit(winner) : ptr_q;
        cdb_valid_d = grant_any;
        cdb_tag_d   = grant_any ? sel_tag   : cdb_tag_q;
        cdb_value_d = grant_any ? sel_value : cdb_value_q;
        cdb_unit_d  = grant_any ? winner    : cdb_unit_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= UNIT_ALU;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            cdb_unit_q  <= UNIT_ALU;
        end else begin
            ptr_q       <= ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
            cdb_unit_q  <= cdb_unit_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_value = cdb_value_q;
    assign cdb_unit  = cdb_unit_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: vector table, multi-cycle corner sequences and random traffic
// checked every cycle against a queue-based model of the broadcast rules.
module tb_cdb_arbiter;
    import tomasulo_pkg::*;

    localparam int unsigned TAG_W  = DEFAULT_TAG_W;
    localparam int unsigned DATA_W = DEFAULT_DATA_W;
`ifdef CDB_DEEP_BUFFER_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic              clk;
    logic              rst;
    logic [2:0]        fu_valid;
    logic [2:0]        fu_ready;
    logic [TAG_W-1:0]  fu_tag   [3];
    logic [DATA_W-1:0] fu_value [3];
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic [1:0]        cdb_unit;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    logic [2:0] dut_acc = '0;

    cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .fu_valid  (fu_valid),
        .fu_tag    (fu_tag),
        .fu_value  (fu_value),
        .fu_ready  (fu_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .cdb_unit  (cdb_unit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Handshakes that completed on the last rising edge.
    always @(posedge clk) dut_acc <= rst ? 3'b000 : (fu_valid & fu_ready);

    // Reference model: one queue per unit, pointer as an integer mod 3.
    cdb_result_t mq [3][$];
    int          mptr = 0;
    cdb_result_t mexp = '0;

    always @(posedge clk) begin : model_b
        int          gu;
        bit          gv;
        bit [2:0]    acc;
        cdb_result_t e;
        if (rst) begin
            for (int u = 0; u < 3; u++) mq[u].delete();
            mptr = 0;
            mexp = '0;
        end else begin
            gv = 0;
            gu = 0;
            for (int k = 0; k < 3; k++) begin
                if (!gv && mq[(mptr + k) % 3].size() != 0) begin
                    gv = 1;
                    gu = (mptr + k) % 3;
                end
            end
            for (int u = 0; u < 3; u++) acc[u] = fu_valid[u] && (mq[u].size() < DEPTH);
            mexp.valid = gv;
            if (gv) begin
                mexp       = mq[gu].pop_front();
                mexp.valid = 1'b1;
                mptr       = (gu + 1) % 3;
            end
            for (int u = 0; u < 3; u++) begin
                if (acc[u]) begin
                    e.valid = 1'b1;
                    e.tag   = fu_tag[u];
                    e.value = fu_value[u];
                    e.unit  = 2'(u);
                    mq[u].push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin : model_chk_b
        logic [2:0] rexp;
        if (chk_en) begin
            for (int u = 0; u < 3; u++) rexp[u] = (mq[u].size() < DEPTH);
            check("model_cdb_valid", 64'(cdb_valid), 64'(mexp.valid));
            check("model_cdb_tag",   64'(cdb_tag),   64'(mexp.tag));
            check("model_cdb_value", 64'(cdb_value), 64'(mexp.value));
            check("model_cdb_unit",  64'(cdb_unit),  64'(mexp.unit));
            check("model_fu_ready",  64'(fu_ready),  64'(rexp));
            check("model_rr_ptr",    64'(dut.ptr_q), 64'(mptr));
        end
    end

    // A stalled producer must keep its offer unchanged.
    logic [2:0]        stall_q = '0;
    logic [TAG_W-1:0]  stall_tag [3];
    logic [DATA_W-1:0] stall_val [3];
    always @(posedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (stall_q[u] && !rst)
                assert (fu_valid[u] && fu_tag[u] == stall_tag[u] && fu_value[u] == stall_val[u])
                else $error("producer %0d changed a stalled offer", u);
            stall_q[u]   <= fu_valid[u] & ~fu_ready[u] & ~rst;
            stall_tag[u] <= fu_tag[u];
            stall_val[u] <= fu_value[u];
        end
    end

    typedef struct {
        logic              r;
        logic [2:0]        v;
        logic [TAG_W-1:0]  t [3];
        logic [DATA_W-1:0] base;
        logic              ecv;
        logic [TAG_W-1:0]  etag;
        logic [DATA_W-1:0] eval;
        logic [1:0]        eunit;
        logic [2:0]        erdy;
    } vec_t;

    function automatic vec_t mk(input int r, input int v, input int t0, input int t1, input int t2,
                                input int base, input int ecv, input int et, input int ev,
                                input int eu, input int rdy1, input int rdy2);
        vec_t x;
        x.r     = 1'(r);
        x.v     = 3'(v);
        x.t[0]  = TAG_W'(t0);
        x.t[1]  = TAG_W'(t1);
        x.t[2]  = TAG_W'(t2);
        x.base  = DATA_W'(base);
        x.ecv   = 1'(ecv);
        x.etag  = TAG_W'(et);
        x.eval  = DATA_W'(ev);
        x.eunit = 2'(eu);
        x.erdy  = (DEPTH == 1) ? 3'(rdy1) : 3'(rdy2);
        return x;
    endfunction

    // Present a new offer only once the previous one has been taken.
    task automatic offer(input int u, input bit want, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        if (fu_valid[u] && !dut_acc[u]) return;
        fu_valid[u] = want;
        if (want) begin
            fu_tag[u]   = t;
            fu_value[u] = d;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        fu_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs [$];
    int   grants [$];
    int   f1tags [$];
    int   pct [3];

    initial begin
        rst      = 1'b1;
        fu_valid = '0;
        for (int u = 0; u < 3; u++) begin
            fu_tag[u]   = '0;
            fu_value[u] = '0;
        end
        repeat (2) @(negedge clk);
        chk_en = 1;

        // Single result, then three-way collision, then single-slot backpressure.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,     0, 0, 0,     0, 7, 7));
        vecs.push_back(mk(0, 1, 3, 0, 0, 'hA,   0, 0, 0,     0, 6, 7));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,     1, 3, 'hA,   0, 7, 7));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,     0, 3, 'hA,   0, 7, 7));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,     0, 0, 0,     0, 7, 7));
        vecs.push_back(mk(0, 7, 1, 2, 3, 'h20,  0, 0, 0,     0, 0, 7));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,     1, 1, 'h20,  0, 1, 7));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,     1, 2, 'h21,  1, 3, 7));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,     1, 3, 'h22,  2, 7, 7));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,     0, 3, 'h22,  2, 7, 7));
`ifndef CDB_DEEP_BUFFER_EN
        vecs.push_back(mk(0, 4, 0, 0, 5, 'h50,  0, 3, 'h22,  2, 3, 3));
        vecs.push_back(mk(0, 4, 0, 0, 6, 'h60,  1, 5, 'h52,  2, 7, 7));
        vecs.push_back(mk(0, 4, 0, 0, 6, 'h60,  0, 5, 'h52,  2, 3, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,     1, 6, 'h62,  2, 7, 7));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,     0, 6, 'h62,  2, 7, 7));
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            rst      = vecs[i].r;
            fu_valid = vecs[i].v;
            for (int u = 0; u < 3; u++) begin
                fu_tag[u]   = vecs[i].t[u];
                fu_value[u] = vecs[i].base + DATA_W'(u);
            end
            @(negedge clk);
            check($sformatf("vec%0d_cdb_valid", i), 64'(cdb_valid), 64'(vecs[i].ecv));
            check($sformatf("vec%0d_cdb_tag", i),   64'(cdb_tag),   64'(vecs[i].etag));
            check($sformatf("vec%0d_cdb_value", i), 64'(cdb_value), 64'(vecs[i].eval));
            check($sformatf("vec%0d_cdb_unit", i),  64'(cdb_unit),  64'(vecs[i].eunit));
            check($sformatf("vec%0d_fu_ready", i),  64'(fu_ready),  64'(vecs[i].erdy));
        end

        // Fairness: F0 and F1 offer continuously for six cycles.
        do_reset();
        grants.delete();
        for (int c = 0; c < 20; c++) begin
            for (int u = 0; u < 2; u++) offer(u, c < 6, TAG_W'(c + 8 * u), DATA_W'(c * 16 + u));
            @(negedge clk);
            if (cdb_valid) grants.push_back(int'(cdb_unit));
        end
        check("fair_grant_count", 64'(grants.size() >= 4), 64'(1));
        for (int i = 0; i < 4; i++)
            if (i < grants.size()) check($sformatf("fair_grant%0d", i), 64'(grants[i]), 64'(i % 2));

        // Reset with two slots full; an offer during reset must be ignored.
        do_reset();
        fu_valid  = 3'b011;
        fu_tag[0] = TAG_W'(9);
        fu_tag[1] = TAG_W'(10);
        @(negedge clk);
        fu_valid  = 3'b100;
        fu_tag[2] = TAG_W'(11);
        rst       = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        fu_valid = '0;
        check("rst_ptr", 64'(dut.ptr_q), 64'(0));
        check("rst_cdb_valid", 64'(cdb_valid), 64'(0));
        check("rst_fu_ready", 64'(fu_ready), 64'(7));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rst_idle%0d_cdb_valid", c), 64'(cdb_valid), 64'(0));
            check($sformatf("rst_idle%0d_fu_ready", c), 64'(fu_ready), 64'(7));
        end

`ifdef CDB_DEEP_BUFFER_EN
        // F1 sends two back-to-back while F0 floods the bus.
        do_reset();
        f1tags.delete();
        for (int c = 0; c < 16; c++) begin
            offer(0, c < 10, TAG_W'(c), DATA_W'(c));
            if (c == 0) begin
                check("deep_f1_ready_c0", 64'(fu_ready[1]), 64'(1));
                fu_valid[1] = 1'b1;
                fu_tag[1]   = TAG_W'(7);
                fu_value[1] = DATA_W'('h70);
            end else if (c == 1) begin
                check("deep_f1_ready_c1", 64'(fu_ready[1]), 64'(1));
                fu_tag[1]   = TAG_W'(8);
                fu_value[1] = DATA_W'('h80);
            end else if (c == 2) begin
                fu_valid[1] = 1'b0;
            end
            @(negedge clk);
            if (cdb_valid && cdb_unit == 2'd1) f1tags.push_back(int'(cdb_tag));
        end
        check("deep_f1_count", 64'(f1tags.size()), 64'(2));
        if (f1tags.size() == 2) begin
            check("deep_f1_first", 64'(f1tags[0]), 64'(7));
            check("deep_f1_second", 64'(f1tags[1]), 64'(8));
        end
`endif

        // Random traffic at several load mixes with occasional resets.
        for (int ph = 0; ph < 3; ph++) begin
            case (ph)
                0:       pct = '{90, 90, 90};
                1:       pct = '{30, 60, 10};
                default: pct = '{70, 0, 70};
            endcase
            for (int c = 0; c < 700; c++) begin
                rst = ($urandom_range(299) == 0);
                for (int u = 0; u < 3; u++)
                    offer(u, $urandom_range(99) < pct[u], TAG_W'($urandom), DATA_W'($urandom));
                @(negedge clk);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            for (int u = 0; u < 3; u++) offer(u, 1'b0, '0, '0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
